alu: RTL and testbench

// - Execute (EX) stage of the Windows SCC 16-bit pipeline. It sits between Decode and Memory.
// - Holds the 8x16 architectural register file (R0..R7).
// - Executes ALU-class ops, computes memory addresses, and evaluates branch conditions.
// - Presents registered results to the Memory stage.

---
 rtl/scc_pkg.sv | 42 ++++
 rtl/alu_core.sv | 62 ++++++
 rtl/alu.sv | 160 ++++++++++++++++
 tb/tb_alu.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/scc_pkg.sv
// Shared encodings for the SCC 16-bit pipeline: decode classes, ALU opcodes,
// branch condition codes, special sub-ops and flag bit positions.
package scc_pkg;

    typedef enum logic [1:0] {
        CLS_ALU_REG = 2'b00,
        CLS_ALU_IMM = 2'b01,
        CLS_MEM     = 2'b10,
        CLS_CTRL    = 2'b11
    } cls_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_LSL = 3'b110,
        OP_LSR = 3'b111
    } alu_op_e;

    typedef enum logic [3:0] {
        BC_EQ = 4'h0, BC_NE = 4'h1, BC_CS = 4'h2, BC_CC = 4'h3,
        BC_MI = 4'h4, BC_PL = 4'h5, BC_VS = 4'h6, BC_VC = 4'h7,
        BC_HI = 4'h8, BC_LS = 4'h9, BC_GE = 4'hA, BC_LT = 4'hB,
        BC_GT = 4'hC, BC_LE = 4'hD, BC_AL = 4'hE, BC_NV = 4'hF
    } bcond_e;

    typedef enum logic [3:0] {
        SP_NOP  = 4'b0000,
        SP_HALT = 4'b0001,
        SP_MOV  = 4'b0010,
        SP_MOVT = 4'b0011
    } special_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational arithmetic/logic unit: result and {N,Z,C,V} from A, B and opcode.
module alu_core
    import scc_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [2:0]    op,
    output logic [DW-1:0] result,
    output logic [3:0]    flags
);

    logic [DW:0] w_sum;
    logic [DW:0] w_diff;
    logic [DW:0] w_shl;
    logic [DW:0] w_shr;
    logic        w_c;
    logic        w_v;

    // Extra bit on each shift catches the last bit shifted out (0 for a zero shift)
    always_comb begin
        w_sum  = {1'b0, a} + {1'b0, b};
        w_diff = {1'b0, a} - {1'b0, b};
        w_shl  = {1'b0, a} << b[3:0];
        w_shr  = {a, 1'b0} >> b[3:0];
        result = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (alu_op_e'(op))
            OP_ADD: begin
                result = w_sum[DW-1:0];
                w_c    = w_sum[DW];
                w_v    = (a[DW-1] == b[DW-1]) && (w_sum[DW-1] != a[DW-1]);
            end
            OP_SUB: begin
                result = w_diff[DW-1:0];
                w_c    = ~w_diff[DW];
                w_v    = (a[DW-1] != b[DW-1]) && (w_diff[DW-1] != a[DW-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_LSL: begin
                result = w_shl[DW-1:0];
                w_c    = w_shl[DW];
            end
            OP_LSR: begin
                result = w_shr[DW:1];
                w_c    = w_shr[0];
            end
            default: result = '0;
        endcase
        flags         = 4'b0000;
        flags[FLAG_N] = result[DW-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = w_c;
        flags[FLAG_V] = w_v;
    end

endmodule

// File: rtl/alu.sv
// Execute stage: register file, ALU, address generation, branch evaluation
// and the registered outputs handed to the Memory stage.
module alu
    import scc_pkg::*;
#(
    parameter int DW    = 16,
    parameter int NREGS = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    first_ld,
    input  logic          special_encoding,
    input  logic [3:0]    second_ld,
    input  logic [2:0]    alu_oc,
    input  logic [3:0]    b_cond,
    input  logic [2:0]    dest_reg,
    input  logic [2:0]    pointer_reg,
    input  logic [2:0]    op_1_reg,
    input  logic [2:0]    op_2_reg,
    input  logic [DW-1:0] immediate,
    input  logic [DW-1:0] offset,
    input  logic [3:0]    flags_in,
    output logic [DW-1:0] result,
    output logic [2:0]    dest_out,
    output logic          reg_we,
    output logic [3:0]    flags_out,
    output logic          branch_taken,
    output logic [DW-1:0] branch_offset,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    output logic          halt
);

    logic [DW-1:0] r_regs [NREGS];

    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic [DW-1:0] w_alu_res;
    logic [3:0]    w_alu_flags;
    logic [DW-1:0] w_movt;
    logic          w_cond;
    logic          w_n;
    logic          w_z;
    logic          w_c;
    logic          w_v;

    // Operand fetch: register-class ops take B from the file, immediate-class from the instruction
    always_comb begin
        w_a    = r_regs[op_1_reg];
        w_b    = (cls_e'(first_ld) == CLS_ALU_REG) ? r_regs[op_2_reg] : immediate;
        w_movt = {immediate[7:0], r_regs[dest_reg][7:0]};
    end

    alu_core #(.DW(DW)) u_core (
        .a      (w_a),
        .b      (w_b),
        .op     (alu_oc),
        .result (w_alu_res),
        .flags  (w_alu_flags)
    );

    // Branch condition from the incoming flags
    always_comb begin
        w_n    = flags_in[FLAG_N];
        w_z    = flags_in[FLAG_Z];
        w_c    = flags_in[FLAG_C];
        w_v    = flags_in[FLAG_V];
        w_cond = 1'b0;
        case (bcond_e'(b_cond))
            BC_EQ: w_cond = w_z;
            BC_NE: w_cond = ~w_z;
            BC_CS: w_cond = w_c;
            BC_CC: w_cond = ~w_c;
            BC_MI: w_cond = w_n;
            BC_PL: w_cond = ~w_n;
            BC_VS: w_cond = w_v;
            BC_VC: w_cond = ~w_v;
            BC_HI: w_cond = w_c & ~w_z;
            BC_LS: w_cond = ~w_c | w_z;
            BC_GE: w_cond = (w_n == w_v);
            BC_LT: w_cond = (w_n != w_v);
            BC_GT: w_cond = ~w_z & (w_n == w_v);
            BC_LE: w_cond = w_z | (w_n != w_v);
            BC_AL: w_cond = 1'b1;
            BC_NV: w_cond = 1'b0;
            default: w_cond = 1'b0;
        endcase
    end

    // Register file update and output registers; strobes pulse for one cycle, halt freezes all state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            result        <= '0;
            dest_out      <= '0;
            reg_we        <= 1'b0;
            flags_out     <= '0;
            branch_taken  <= 1'b0;
            branch_offset <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_re        <= 1'b0;
            mem_we        <= 1'b0;
            halt          <= 1'b0;
        end else begin
            reg_we       <= 1'b0;
            mem_re       <= 1'b0;
            mem_we       <= 1'b0;
            branch_taken <= 1'b0;
            if (!halt) begin
                flags_out <= flags_in;
                case (cls_e'(first_ld))
                    CLS_ALU_REG, CLS_ALU_IMM: begin
                        r_regs[dest_reg] <= w_alu_res;
                        result           <= w_alu_res;
                        dest_out         <= dest_reg;
                        reg_we           <= 1'b1;
                        flags_out        <= w_alu_flags;
                    end
                    CLS_MEM: begin
                        mem_addr <= r_regs[pointer_reg] + offset;
                        if (second_ld[0]) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= w_a;
                        end else begin
                            mem_re <= 1'b1;
                        end
                    end
                    CLS_CTRL: begin
                        if (!special_encoding) begin
                            branch_taken  <= w_cond;
                            branch_offset <= offset;
                        end else begin
                            case (special_e'(second_ld))
                                SP_HALT: halt <= 1'b1;
                                SP_MOV: begin
                                    r_regs[dest_reg] <= immediate;
                                    result           <= immediate;
                                    dest_out         <= dest_reg;
                                    reg_we           <= 1'b1;
                                end
                                SP_MOVT: begin
                                    r_regs[dest_reg] <= w_movt;
                                    result           <= w_movt;
                                    dest_out         <= dest_reg;
                                    reg_we           <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed testbench for the SCC execute stage.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [1:0]  first_ld;
    logic        special_encoding;
    logic [3:0]  second_ld;
    logic [2:0]  alu_oc;
    logic [3:0]  b_cond;
    logic [2:0]  dest_reg;
    logic [2:0]  pointer_reg;
    logic [2:0]  op_1_reg;
    logic [2:0]  op_2_reg;
    logic [15:0] immediate;
    logic [15:0] offset;
    logic [3:0]  flags_in;
    logic [15:0] result;
    logic [2:0]  dest_out;
    logic        reg_we;
    logic [3:0]  flags_out;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic        halt;

    int total = 0;
    int bad   = 0;

    alu dut (
        .clk              (clk),
        .rst              (rst),
        .first_ld         (first_ld),
        .special_encoding (special_encoding),
        .second_ld        (second_ld),
        .alu_oc           (alu_oc),
        .b_cond           (b_cond),
        .dest_reg         (dest_reg),
        .pointer_reg      (pointer_reg),
        .op_1_reg         (op_1_reg),
        .op_2_reg         (op_2_reg),
        .immediate        (immediate),
        .offset           (offset),
        .flags_in         (flags_in),
        .result           (result),
        .dest_out         (dest_out),
        .reg_we           (reg_we),
        .flags_out        (flags_out),
        .branch_taken     (branch_taken),
        .branch_offset    (branch_offset),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_re           (mem_re),
        .mem_we           (mem_we),
        .halt             (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default instruction is a special NOP with all fields zero
    task automatic idle();
        first_ld = 2'b11; special_encoding = 1'b1; second_ld = 4'h0;
        alu_oc = 3'd0; b_cond = 4'h0; dest_reg = 3'd0; pointer_reg = 3'd0;
        op_1_reg = 3'd0; op_2_reg = 3'd0; immediate = 16'h0; offset = 16'h0;
        flags_in = 4'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mov(input logic [2:0] d, input logic [15:0] imm);
        idle();
        second_ld = 4'b0010; dest_reg = d; immediate = imm;
        tick();
    endtask

    task automatic alu_op(input logic [1:0] cls, input logic [2:0] oc, input logic [2:0] d,
                          input logic [2:0] a, input logic [2:0] b, input logic [15:0] imm,
                          input logic [3:0] fin);
        idle();
        first_ld = cls; alu_oc = oc; dest_reg = d; op_1_reg = a; op_2_reg = b;
        immediate = imm; flags_in = fin;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        total++; if (result !== 16'h0) begin bad++; $display("FAIL reset_result got=%h want=0000", result); end
        total++; if (flags_out !== 4'h0) begin bad++; $display("FAIL reset_flags got=%b want=0000", flags_out); end
        total++; if ({reg_we, mem_re, mem_we, branch_taken, halt} !== 5'b0) begin bad++; $display("FAIL reset_strobes got=%b want=00000", {reg_we, mem_re, mem_we, branch_taken, halt}); end
        total++; if ({mem_addr, mem_wdata, branch_offset} !== 48'h0) begin bad++; $display("FAIL reset_data got=%h want=0", {mem_addr, mem_wdata, branch_offset}); end
        rst = 1'b0;
    endtask

    task automatic test_mov_add();
        mov(3'd1, 16'h7FFF);
        total++; if (result !== 16'h7FFF || reg_we !== 1'b1 || dest_out !== 3'd1) begin bad++; $display("FAIL mov_r1 got=%h/%b/%0d want=7fff/1/1", result, reg_we, dest_out); end
        mov(3'd2, 16'h0001);
        alu_op(2'b00, 3'b000, 3'd3, 3'd1, 3'd2, 16'h0, 4'h0);
        total++; if (result !== 16'h8000) begin bad++; $display("FAIL add_result got=%h want=8000", result); end
        total++; if (flags_out !== 4'b1001) begin bad++; $display("FAIL add_flags got=%b want=1001", flags_out); end
        total++; if (reg_we !== 1'b1 || dest_out !== 3'd3) begin bad++; $display("FAIL add_we got=%b/%0d want=1/3", reg_we, dest_out); end
    endtask

    task automatic test_sub();
        alu_op(2'b00, 3'b001, 3'd4, 3'd2, 3'd2, 16'h0, 4'h0);
        total++; if (result !== 16'h0000 || flags_out !== 4'b0110) begin bad++; $display("FAIL sub_zero got=%h/%b want=0000/0110", result, flags_out); end
        alu_op(2'b01, 3'b001, 3'd7, 3'd0, 3'd0, 16'h0001, 4'h0);
        total++; if (result !== 16'hFFFF || flags_out !== 4'b1000) begin bad++; $display("FAIL sub_borrow got=%h/%b want=ffff/1000", result, flags_out); end
    endtask

    task automatic test_logic();
        alu_op(2'b00, 3'b010, 3'd7, 3'd1, 3'd2, 16'h0, 4'hF);
        total++; if (result !== 16'h0001 || flags_out !== 4'b0000) begin bad++; $display("FAIL and got=%h/%b want=0001/0000", result, flags_out); end
        alu_op(2'b00, 3'b011, 3'd7, 3'd1, 3'd2, 16'h0, 4'hF);
        total++; if (result !== 16'h7FFF || flags_out !== 4'b0000) begin bad++; $display("FAIL or got=%h/%b want=7fff/0000", result, flags_out); end
        alu_op(2'b00, 3'b100, 3'd7, 3'd1, 3'd2, 16'h0, 4'hF);
        total++; if (result !== 16'h7FFE || flags_out !== 4'b0000) begin bad++; $display("FAIL xor got=%h/%b want=7ffe/0000", result, flags_out); end
        alu_op(2'b00, 3'b101, 3'd7, 3'd1, 3'd2, 16'h0, 4'hF);
        total++; if (result !== 16'h8000 || flags_out !== 4'b1000) begin bad++; $display("FAIL not got=%h/%b want=8000/1000", result, flags_out); end
    endtask

    task automatic test_shift();
        mov(3'd6, 16'h8001);
        alu_op(2'b01, 3'b110, 3'd7, 3'd6, 3'd0, 16'h0001, 4'h0);
        total++; if (result !== 16'h0002 || flags_out !== 4'b0010) begin bad++; $display("FAIL lsl1 got=%h/%b want=0002/0010", result, flags_out); end
        mov(3'd6, 16'h0003);
        alu_op(2'b01, 3'b111, 3'd7, 3'd6, 3'd0, 16'h0000, 4'hF);
        total++; if (result !== 16'h0003 || flags_out !== 4'b0000) begin bad++; $display("FAIL lsr0 got=%h/%b want=0003/0000", result, flags_out); end
        alu_op(2'b01, 3'b111, 3'd7, 3'd6, 3'd0, 16'h0001, 4'h0);
        total++; if (result !== 16'h0001 || flags_out !== 4'b0010) begin bad++; $display("FAIL lsr1 got=%h/%b want=0001/0010", result, flags_out); end
    endtask

    task automatic test_movt();
        mov(3'd1, 16'h1234);
        idle();
        second_ld = 4'b0011; dest_reg = 3'd1; immediate = 16'h00AB; flags_in = 4'b0101;
        tick();
        total++; if (result !== 16'hAB34 || reg_we !== 1'b1 || flags_out !== 4'b0101) begin bad++; $display("FAIL movt got=%h/%b/%b want=ab34/1/0101", result, reg_we, flags_out); end
    endtask

    task automatic test_memory();
        mov(3'd5, 16'h1000);
        idle();
        first_ld = 2'b10; second_ld = 4'b0001; pointer_reg = 3'd5; offset = 16'hFFFE; op_1_reg = 3'd3;
        tick();
        total++; if (mem_addr !== 16'h0FFE) begin bad++; $display("FAIL store_addr got=%h want=0ffe", mem_addr); end
        total++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || reg_we !== 1'b0) begin bad++; $display("FAIL store_strobes got=%b%b%b want=100", mem_we, mem_re, reg_we); end
        total++; if (mem_wdata !== 16'h8000) begin bad++; $display("FAIL store_wdata got=%h want=8000", mem_wdata); end
        idle();
        first_ld = 2'b10; second_ld = 4'b0000; pointer_reg = 3'd5; offset = 16'h0002;
        tick();
        total++; if (mem_addr !== 16'h1002 || mem_re !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL load got=%h/%b%b want=1002/10", mem_addr, mem_re, mem_we); end
        idle();
        tick();
        total++; if (mem_re !== 1'b0) begin bad++; $display("FAIL load_pulse got=%b want=0", mem_re); end
    endtask

    task automatic test_branch();
        logic [3:0]  conds [5] = '{4'h0, 4'hB, 4'hF, 4'h8, 4'hC};
        logic [3:0]  fins  [5] = '{4'b0100, 4'b1000, 4'b1111, 4'b0010, 4'b0100};
        logic        exps  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            idle();
            special_encoding = 1'b0; b_cond = conds[i]; flags_in = fins[i]; offset = 16'h0040 + 16'(i);
            tick();
            total++; if (branch_taken !== exps[i]) begin bad++; $display("FAIL branch_cond%h got=%b want=%b", conds[i], branch_taken, exps[i]); end
            total++; if (branch_offset !== 16'h0040 + 16'(i) || flags_out !== fins[i]) begin bad++; $display("FAIL branch_pass%h got=%h/%b want=%h/%b", conds[i], branch_offset, flags_out, 16'h0040 + 16'(i), fins[i]); end
        end
        idle();
        tick();
        total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL branch_pulse got=%b want=0", branch_taken); end
    endtask

    task automatic test_halt();
        mov(3'd6, 16'h00C3);
        idle();
        second_ld = 4'b0001;
        tick();
        total++; if (halt !== 1'b1 || reg_we !== 1'b0) begin bad++; $display("FAIL halt_set got=%b/%b want=1/0", halt, reg_we); end
        alu_op(2'b00, 3'b000, 3'd3, 3'd1, 3'd2, 16'h0, 4'hF);
        total++; if (halt !== 1'b1 || reg_we !== 1'b0) begin bad++; $display("FAIL halt_sticky got=%b/%b want=1/0", halt, reg_we); end
        total++; if (result !== 16'h00C3 || flags_out !== 4'h0) begin bad++; $display("FAIL halt_hold got=%h/%b want=00c3/0000", result, flags_out); end
        mov(3'd7, 16'h0005);
        total++; if (reg_we !== 1'b0 || result !== 16'h00C3) begin bad++; $display("FAIL halt_mov got=%b/%h want=0/00c3", reg_we, result); end
    endtask

    task automatic test_reset_mid();
        idle();
        second_ld = 4'b0010; dest_reg = 3'd1; immediate = 16'hBEEF; flags_in = 4'hF;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (result !== 16'h0 || reg_we !== 1'b0 || halt !== 1'b0) begin bad++; $display("FAIL rst_mid got=%h/%b/%b want=0000/0/0", result, reg_we, halt); end
        total++; if (flags_out !== 4'h0 || mem_addr !== 16'h0 || dest_out !== 3'd0) begin bad++; $display("FAIL rst_mid_data got=%b/%h/%0d want=0000/0000/0", flags_out, mem_addr, dest_out); end
        for (int i = 0; i < 8; i++) begin
            idle();
            first_ld = 2'b10; second_ld = 4'b0001; op_1_reg = 3'(i);
            tick();
            total++; if (mem_wdata !== 16'h0 || mem_we !== 1'b1) begin bad++; $display("FAIL rst_reg%0d got=%h/%b want=0000/1", i, mem_wdata, mem_we); end
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_mov_add();
        test_sub();
        test_logic();
        test_shift();
        test_movt();
        test_memory();
        test_branch();
        test_halt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
